// File: rtl/idct_ctrl_pkg.sv
// rtl/idct_ctrl_pkg.sv - shared types and constants for the IDCT sequencing controller
package idct_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROW_ISS,
        ST_ROW_WAIT,
        ST_COL_ISS,
        ST_COL_WAIT,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] MODE_8X8 = 2'b01;
    localparam logic [1:0] MODE_4X4 = 2'b00;

    localparam int N8 = 8;
    localparam int N4 = 4;

    // Wide enough to hold 64 without wrapping.
    localparam int CNT_W = 7;

    function automatic logic mode_is_valid(input logic [1:0] m);
        return (m == MODE_8X8) || (m == MODE_4X4);
    endfunction

endpackage

// File: rtl/idct_idx_cnt.sv
// rtl/idct_idx_cnt.sv - up counter with clear, increment and terminal count against a limit
module idct_idx_cnt
    import idct_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = ((count_q + W'(1)) == limit);

endmodule

// File: rtl/idct_seq_ctrl.sv
// rtl/idct_seq_ctrl.sv - load / row pass / column pass / drain sequencer for the IDCT datapath
module idct_seq_ctrl
    import idct_ctrl_pkg::*;
#(
    parameter int AW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          coef_we,
    output logic [AW-1:0] coef_addr,
    output logic          dp_start,
    output logic          pass,
    output logic [VW-1:0] vec_idx,
    input  logic          dp_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int VEC_W = VW + 1;

    localparam logic [CNT_W-1:0] BLK8 = CNT_W'(N8 * N8);
    localparam logic [CNT_W-1:0] BLK4 = CNT_W'(N4 * N4);
    localparam logic [VEC_W-1:0] VEC8 = VEC_W'(N8);
    localparam logic [VEC_W-1:0] VEC4 = VEC_W'(N4);

    state_e state_q, state_d;
    logic   n8_q, n8_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    logic             cnt_clr, cnt_inc, cnt_last;
    logic             vec_clr, vec_inc, vec_last;
    logic [CNT_W-1:0] cnt, cnt_lim;
    logic [VEC_W-1:0] vec, vec_lim;

    assign cnt_lim = n8_q ? BLK8 : BLK4;
    assign vec_lim = n8_q ? VEC8 : VEC4;

    idct_idx_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_lim),
        .count (cnt),
        .last  (cnt_last)
    );

    idct_idx_cnt #(.W(VEC_W)) u_vec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (vec_clr),
        .inc   (vec_inc),
        .limit (vec_lim),
        .count (vec),
        .last  (vec_last)
    );

    always_comb begin
        state_d = state_q;
        n8_d    = n8_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        vec_clr = 1'b0;
        vec_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_is_valid(mode)) begin
                        n8_d    = (mode == MODE_8X8);
                        cnt_clr = 1'b1;
                        vec_clr = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        vec_clr = 1'b1;
                        state_d = ST_ROW_ISS;
                    end
                end
            end
            // dp_done is only looked at in the WAIT states, never in ISS.
            ST_ROW_ISS: state_d = ST_ROW_WAIT;
            ST_ROW_WAIT: begin
                if (dp_done) begin
                    if (vec_last) begin
                        vec_clr = 1'b1;
                        state_d = ST_COL_ISS;
                    end else begin
                        vec_inc = 1'b1;
                        state_d = ST_ROW_ISS;
                    end
                end
            end
            ST_COL_ISS: state_d = ST_COL_WAIT;
            ST_COL_WAIT: begin
                if (dp_done) begin
                    if (vec_last) begin
                        vec_clr = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        vec_inc = 1'b1;
                        state_d = ST_COL_ISS;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n8_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n8_q    <= n8_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign coef_we   = in_ready & in_valid;
    assign coef_addr = in_ready ? AW'(cnt) : '0;
    assign dp_start  = (state_q == ST_ROW_ISS) || (state_q == ST_COL_ISS);
    assign pass      = (state_q == ST_COL_ISS) || (state_q == ST_COL_WAIT);
    assign vec_idx   = VW'(vec);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_addr  = out_valid ? AW'(cnt) : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_idct_seq_ctrl.sv
// tb/tb_idct_seq_ctrl.sv - table-driven block scenarios plus reserved-mode and mid-block reset sequences
module tb_idct_seq_ctrl;
    import idct_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in_valid = 1'b0;
    logic       dp_done = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, coef_we, dp_start, pass, out_valid, busy, done, err;
    logic [5:0] coef_addr, out_addr;
    logic [2:0] vec_idx;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] mode;
        int         iv_pct;
        int         or_pct;
        int         dly;
        bit         spur;
        bit         bstart;
        bit         b2b;
        int         exp_nn;
        int         exp_nv;
        int         exp_time;
    } blk_t;

    blk_t tbl[7];

    idct_seq_ctrl #(.AW(6), .VW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .dp_start  (dp_start),
        .pass      (pass),
        .vec_idx   (vec_idx),
        .dp_done   (dp_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_b({tag, "_in_ready"}, in_ready, 1'b0);
        chk_b({tag, "_coef_we"}, coef_we, 1'b0);
        chk_b({tag, "_dp_start"}, dp_start, 1'b0);
        chk_b({tag, "_pass"}, pass, 1'b0);
        chk_b({tag, "_out_valid"}, out_valid, 1'b0);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_done"}, done, 1'b0);
        chk_b({tag, "_err"}, err, 1'b0);
        chk_i({tag, "_coef_addr"}, int'(coef_addr), 0);
        chk_i({tag, "_out_addr"}, int'(out_addr), 0);
        chk_i({tag, "_vec_idx"}, int'(vec_idx), 0);
    endtask

    // One whole block; dp_done answers each dp_start after b.dly cycles.
    task automatic run_block(input blk_t b);
        int ci, oi, rows, cols, nerr, dn, cyc;
        int done_at, last_we, first_ds, last_dd, first_ov;
        ci = 0; oi = 0; rows = 0; cols = 0; nerr = 0; dn = 0; cyc = 0;
        done_at = -10; last_we = -1; first_ds = -1; last_dd = -1; first_ov = -1;
        if (!b.b2b) begin
            @(posedge clk); #1;
            chk_b("done_single", done, 1'b0);
            chk_b("idle_busy", busy, 1'b0);
        end
        dp_done = 1'b0;
        start = 1'b1;
        mode = b.mode;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~b.mode;
        chk_b("load_ready", in_ready, 1'b1);
        while (cyc < 3000) begin
            in_valid  = (int'($urandom_range(0, 99)) < b.iv_pct);
            out_ready = (int'($urandom_range(0, 99)) < b.or_pct);
            dp_done   = (cyc == done_at) || (b.spur && in_ready);
            if (cyc == done_at && pass) last_dd = cyc;
            start = b.bstart && busy && !in_ready && !dp_start && !pass && !out_valid;
            if (start) mode = MODE_8X8;
            #1;
            if (coef_we) begin
                chk_i("coef_addr", int'(coef_addr), ci);
                ci++;
                last_we = cyc;
            end
            if (dp_start) begin
                chk_i("vec_idx", int'(vec_idx), pass ? cols : rows);
                if (pass) cols++;
                else rows++;
                done_at = cyc + b.dly;
                if (first_ds < 0) first_ds = cyc;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                chk_i("out_addr", int'(out_addr), oi);
                oi++;
            end
            if (err) nerr++;
            if (done) begin
                dn = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        dp_done = 1'b0;
        chk_i("done_seen", dn, 1);
        chk_b("done_busy", busy, 1'b0);
        chk_i("coef_beats", ci, b.exp_nn);
        chk_i("row_starts", rows, b.exp_nv);
        chk_i("col_starts", cols, b.exp_nv);
        chk_i("out_beats", oi, b.exp_nn);
        chk_i("err_in_block", nerr, 0);
        chk_i("load_to_dp_start", first_ds - last_we, 1);
        chk_i("dp_done_to_out_valid", first_ov - last_dd, 1);
        if (b.exp_time != 0) chk_i("block_time", cyc + 1, b.exp_time);
    endtask

    initial begin
        int n;
        blk_t after_rst;
        tbl[0] = '{MODE_8X8, 100, 100, 3, 1'b0, 1'b0, 1'b0, 64, 8, 0};
        tbl[1] = '{MODE_4X4, 100, 100, 3, 1'b0, 1'b0, 1'b0, 16, 4, 0};
        tbl[2] = '{MODE_8X8,  60,  50, 1, 1'b0, 1'b0, 1'b0, 64, 8, 0};
        tbl[3] = '{MODE_4X4,  40,  70, 2, 1'b1, 1'b1, 1'b0, 16, 4, 0};
        tbl[4] = '{MODE_4X4, 100, 100, 1, 1'b0, 1'b0, 1'b1, 16, 4, 49};
        tbl[5] = '{MODE_8X8, 100, 100, 1, 1'b0, 1'b0, 1'b1, 64, 8, 161};
        tbl[6] = '{MODE_8X8,  70,  30, 2, 1'b1, 1'b0, 1'b0, 64, 8, 0};
        after_rst = '{MODE_4X4, 100, 100, 2, 1'b0, 1'b0, 1'b0, 16, 4, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_block(tbl[i]);

        // Reserved modes: err pulse, controller stays idle.
        @(posedge clk); #1;
        mode = 2'b10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = MODE_4X4;
        chk_b("err_10", err, 1'b1);
        chk_b("busy_10", busy, 1'b0);
        chk_b("ready_10", in_ready, 1'b0);
        @(posedge clk); #1;
        chk_b("err_10_pulse", err, 1'b0);
        chk_b("busy_10_after", busy, 1'b0);
        mode = 2'b11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk_b("err_11", err, 1'b1);
        chk_b("busy_11", busy, 1'b0);

        // Reset while in COL_WAIT.
        @(posedge clk); #1;
        mode = MODE_8X8;
        start = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!dp_start && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (!(pass && !dp_start) && n < 200) begin
            dp_done = !dp_start;
            @(posedge clk); #1;
            n++;
        end
        dp_done = 1'b0;
        chk_b("reach_col_wait", pass && !dp_start && busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        chk_b("rst_hold_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_b("no_done_after_rst", done, 1'b0);
        end
        run_block(after_rst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idct_seq_ctrl.md
# idct_seq_ctrl

Sequencing controller for the 16-bit IDCT datapath (`idct_top`). It accepts one coefficient block per `start`, either 8x8 or 4x4 as selected by `mode`. It then drives the datapath through a row pass and a column pass of 1-D transforms, and streams the result buffer out over a valid/ready handshake. It replaces the free-running stimulus counters currently used to feed `idct_top`.

## Interface

Parameters:
- `AW`, default 6: coefficient/result buffer address width (64 entries).
- `VW`, default 3: vector index width (max 8 vectors per pass).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a block; sampled only in IDLE.
- `mode` in 2: `2'b01` selects 8x8 (N=8); `2'b00` selects 4x4 (N=4); `2'b1x` is reserved. Latched at accepted `start`.
- `in_valid` in 1: coefficient beat valid.
- `in_ready` out 1: controller accepts a coefficient beat.
- `coef_we` out 1: coefficient buffer write enable.
- `coef_addr` out AW: coefficient buffer write address, row-major.
- `dp_start` out 1: one-cycle pulse; datapath starts a 1-D transform.
- `pass` out 1: 0 = row pass, 1 = column pass.
- `vec_idx` out VW: row or column index for the current transform.
- `dp_done` in 1: datapath pulse; current transform complete.
- `out_valid` out 1: result read address valid.
- `out_ready` in 1: consumer accepts the result beat.
- `out_addr` out AW: result buffer read address, row-major.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at block completion.
- `err` out 1: one-cycle pulse when `start` is given with a reserved `mode`.

## Operation

States: IDLE, LOAD, ROW_ISS, ROW_WAIT, COL_ISS, COL_WAIT, DRAIN.

- IDLE:
  - `start` with a valid `mode`: latch N, clear `cnt`, go to LOAD.
  - `start` with a reserved `mode`: pulse `err`, stay in IDLE.
- LOAD:
  - `in_ready`=1.
  - A beat is accepted when `in_valid&in_ready`. On accept: `coef_we`=1 combinationally with `coef_addr`=`cnt`, then `cnt`++.
  - On the N*N-th accept: `vec_idx`=0, go to ROW_ISS.
- ROW_ISS: `dp_start`=1, `pass`=0. Always exactly one cycle, then ROW_WAIT.
- ROW_WAIT:
  - Waits on `dp_done`.
  - On `dp_done` with `vec_idx`<N-1: `vec_idx`++, go to ROW_ISS.
  - On `dp_done` with `vec_idx`=N-1: `vec_idx`=0, go to COL_ISS.
- COL_ISS / COL_WAIT: identical to the row states with `pass`=1. After the last vector: clear `cnt`, go to DRAIN.
- DRAIN:
  - `out_valid`=1, `out_addr`=`cnt`.
  - `cnt` advances on `out_valid&out_ready`.
  - On the N*N-th beat: go to IDLE; `done` pulses in the first IDLE cycle.
- Addressing is `addr = r*N + c`. A 4x4 block uses addresses 0..15 only.
- `cnt` is 7 bits internally so that it can hold 64 without wrap. Terminal compare is against N*N (64 or 16).
- `dp_done` is ignored outside the *_WAIT states. It is also ignored in the same cycle as `dp_start`.
- `start` while `busy` is ignored. `mode` changes after latch have no effect on the current block.
- Reset mid-block: immediate return to IDLE, all counters cleared, no `done`. Buffer contents are don't-care.

## Timing

- Reset values:
  - state IDLE; `cnt`=0; `vec_idx`=0; N=8.
  - `in_ready`, `coef_we`, `dp_start`, `pass`, `out_valid`, `busy`, `done`, `err` all 0.
  - `coef_addr`=0; `out_addr`=0.
- Output registration: all outputs are decoded from registered state and counters; `coef_we` additionally uses `in_valid`. No combinational path from `out_ready` to `out_valid`.
- Cycle-level latencies:
  - `start` accepted at cycle t: `in_ready`=1 at t+1.
  - Last coefficient accepted at t: `dp_start` at t+1.
  - `dp_done` at u: next `dp_start` at u+1.
  - Last column `dp_done` at u: `out_valid` at u+1.
- Minimum per vector is 2 cycles (ISS plus a `dp_done` in the first WAIT cycle).
- Minimum block time:
  - 8x8: 1 + 64 + 16 + 16 + 64 cycles.
  - 4x4: 1 + 16 + 8 + 8 + 16 cycles.
- `done` cycle is IDLE: a `start` in that cycle is accepted, giving back-to-back blocks.

## Structure

- Package `idct_ctrl_pkg`:
  - state enum;
  - `MODE_8X8`=2'b01, `MODE_4X4`=2'b00;
  - `N8`=8, `N4`=4.
- Sub-module `idct_idx_cnt`: up counter with clear, increment and terminal-count-against-limit. Instantiated twice, once for `cnt` and once for `vec_idx`.

## Test plan

- 8x8 nominal:
  - Stimulus: `mode`=01, `start`, coefficients 0..63 with `in_valid` held high, `dp_done` 3 cycles after each `dp_start`, `out_ready`=1.
  - Required: `coef_addr` runs 0..63; exactly 8 row and 8 column `dp_start` pulses with `vec_idx` 0..7; `out_addr` runs 0..63; one `done` pulse.
- 4x4 nominal:
  - Stimulus: `mode`=00, 16 coefficients.
  - Required: `coef_addr` runs 0..15; 4+4 `dp_start` pulses; 16 output beats; `done`.
- Backpressure:
  - Stimulus: `in_valid` and `out_ready` toggled pseudo-randomly.
  - Required: address advances only on handshake; no address skipped or repeated; total beats 64.
- Reserved mode and busy start:
  - Stimulus: `start` with `mode`=10; also `start` during ROW_WAIT.
  - Required: `mode`=10 gives `err` pulse, `busy` stays 0; the ROW_WAIT `start` is ignored.
- Spurious `dp_done` and back-to-back:
  - Stimulus: `dp_done` during LOAD; `start` in the `done` cycle.
  - Required: `dp_done` in LOAD has no effect; the second block enters LOAD the next cycle.
- Reset mid-block:
  - Stimulus: `rst_n` low during COL_WAIT.
  - Required: all outputs return to reset values asynchronously; no `done`; a new 4x4 block then completes normally.
